// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU bus: ROM below ROM_LIMIT, RAM above it,
// fixed wait-state insertion and a one-cycle mem_ready/bus_err completion pulse.
module cpu_mem_responder #(
    parameter logic [15:0] ROM_LIMIT   = 16'h0100,
    parameter int          RAM_DEPTH   = 256,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] addr_bus,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [7:0]  wr_data,
    output logic [7:0]  rd_data,
    output logic        rd_data_oe,
    output logic        mem_ready,
    output logic        bus_err,
    input  logic        load_en,
    input  logic [7:0]  load_addr,
    input  logic [7:0]  load_data
);

    localparam int          RAM_AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam logic [16:0] RAM_SPAN  = 17'(RAM_DEPTH);
    localparam bit          NO_WAIT   = (WAIT_STATES == 0);
    localparam logic [3:0]  WAIT_LAST = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [7:0] rom [256];
    logic [7:0] ram [RAM_DEPTH];

    state_t             state, state_nxt;
    logic [3:0]         wait_cnt;
    logic [15:0]        addr_q;
    logic [7:0]         data_q;
    logic               rd_q, wr_q;

    logic [15:0]        acc_addr;
    logic [7:0]         acc_data;
    logic               acc_rd, acc_wr;
    logic [15:0]        ram_off;
    logic [RAM_AW-1:0]  ram_idx;
    logic               hit_rom, hit_ram, conflict;
    logic               resp_go, acc_err, ram_we;
    logic [7:0]         read_val;

    always_comb begin
        state_nxt = state;
        resp_go   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read || mem_write) begin
                    state_nxt = NO_WAIT ? RESP : WAIT;
                    resp_go   = NO_WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == WAIT_LAST) begin
                    state_nxt = RESP;
                    resp_go   = 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // With no wait states the access resolves on the sampling edge itself,
    // so decode looks at the live bus in IDLE and at the latched copy otherwise.
    always_comb begin
        acc_addr = addr_q;
        acc_data = data_q;
        acc_rd   = rd_q;
        acc_wr   = wr_q;
        if (state == IDLE) begin
            acc_addr = addr_bus;
            acc_data = wr_data;
            acc_rd   = mem_read;
            acc_wr   = mem_write;
        end

        ram_off  = acc_addr - ROM_LIMIT;
        ram_idx  = ram_off[RAM_AW-1:0];
        hit_rom  = (acc_addr < ROM_LIMIT);
        hit_ram  = !hit_rom && ({1'b0, ram_off} < RAM_SPAN);
        conflict = acc_rd && acc_wr;
        acc_err  = conflict || !(hit_rom || hit_ram) || (acc_wr && hit_rom);
        ram_we   = reset_n && resp_go && acc_wr && !conflict && hit_ram;

        read_val = 8'h00;
        if (acc_rd && !conflict) begin
            if (hit_rom)
                read_val = rom[acc_addr[7:0]];
            else if (hit_ram)
                read_val = ram[ram_idx];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state == WAIT) ? wait_cnt + 4'd1 : 4'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_ready  <= 1'b0;
            bus_err    <= 1'b0;
            rd_data_oe <= 1'b0;
            rd_data    <= 8'h00;
        end else if (resp_go) begin
            mem_ready  <= 1'b1;
            bus_err    <= acc_err;
            rd_data_oe <= acc_rd && !conflict;
            rd_data    <= read_val;
        end else begin
            mem_ready  <= 1'b0;
            bus_err    <= 1'b0;
            rd_data_oe <= 1'b0;
            rd_data    <= 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            addr_q <= addr_bus;
            data_q <= wr_data;
            rd_q   <= mem_read;
            wr_q   <= mem_write;
        end
    end

    // Read capture sees the pre-load value when a preload hits the same edge.
    always_ff @(posedge clk) begin
        if (load_en)
            rom[load_addr] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (ram_we)
            ram[ram_idx] <= acc_data;
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Randomised bench for cpu_mem_responder: one instance with one wait state and
// one with none, checked against an array-based model of the memory map.
module tb_cpu_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] addr_bus;
    logic        mem_read, mem_write;
    logic [7:0]  wr_data;
    logic        load_en;
    logic [7:0]  load_addr, load_data;
    logic        sel;

    logic        rd_a, wr_a, rd_b, wr_b;
    logic [7:0]  rd_data_a, rd_data_b;
    logic        oe_a, oe_b, rdy_a, rdy_b, err_a, err_b;
    logic [7:0]  o_data;
    logic        o_oe, o_rdy, o_err;

    always #5 clk = ~clk;

    assign rd_a   = mem_read  & ~sel;
    assign wr_a   = mem_write & ~sel;
    assign rd_b   = mem_read  &  sel;
    assign wr_b   = mem_write &  sel;
    assign o_data = sel ? rd_data_b : rd_data_a;
    assign o_oe   = sel ? oe_b  : oe_a;
    assign o_rdy  = sel ? rdy_b : rdy_a;
    assign o_err  = sel ? err_b : err_a;

    cpu_mem_responder #(.WAIT_STATES(1)) dut_w1 (
        .clk(clk), .reset_n(reset_n), .addr_bus(addr_bus),
        .mem_read(rd_a), .mem_write(wr_a), .wr_data(wr_data),
        .rd_data(rd_data_a), .rd_data_oe(oe_a), .mem_ready(rdy_a), .bus_err(err_a),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    cpu_mem_responder #(.WAIT_STATES(0)) dut_w0 (
        .clk(clk), .reset_n(reset_n), .addr_bus(addr_bus),
        .mem_read(rd_b), .mem_write(wr_b), .wr_data(wr_data),
        .rd_data(rd_data_b), .rd_data_oe(oe_b), .mem_ready(rdy_b), .bus_err(err_b),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    logic [7:0] rom_m [256];
    logic [7:0] ram_m [2][256];
    bit         ram_v [2][256];
    int         checks = 0;
    int         errors = 0;

    // Memory-map model: outcome of one access, updating storage for legal writes.
    task automatic model_access(input logic [15:0] a, input logic rd, input logic wr,
                                input logic [7:0] d, output logic [7:0] ed,
                                output logic ee, output logic eo, output bit known);
        int k;
        int off;
        k = sel ? 1 : 0;
        ed = 8'h00; ee = 1'b0; eo = 1'b0; known = 1'b1;
        if (rd && wr) begin
            ee = 1'b1;
        end else if (a < 16'h0100) begin
            if (wr) ee = 1'b1;
            else begin eo = 1'b1; ed = rom_m[a[7:0]]; end
        end else if (a < 16'h0200) begin
            off = int'(a) - 256;
            if (wr) begin
                ram_m[k][off] = d;
                ram_v[k][off] = 1'b1;
            end else begin
                eo = 1'b1;
                ed = ram_m[k][off];
                known = ram_v[k][off];
            end
        end else begin
            ee = 1'b1;
            eo = rd;
        end
    endtask

    task automatic do_access(input logic [15:0] a, input logic rd, input logic wr,
                             input logic [7:0] d, input string nm);
        int w;
        logic [7:0] ed;
        logic ee, eo;
        bit known;
        w = sel ? 0 : 1;
        model_access(a, rd, wr, d, ed, ee, eo, known);
        @(negedge clk);
        addr_bus = a; mem_read = rd; mem_write = wr; wr_data = d;
        @(posedge clk);
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0;
        for (int c = 1; c <= w + 2; c++) begin
            if (c > 1) @(negedge clk);
            if (c == w + 1) begin
                checks++;
                if ({o_rdy, o_err, o_oe} !== {1'b1, ee, eo}) begin
                    errors++;
                    $display("FAIL %s resp rdy/err/oe got %b%b%b want 1%b%b", nm, o_rdy, o_err, o_oe, ee, eo);
                end
                if (known) begin
                    checks++;
                    if (o_data !== ed) begin
                        errors++;
                        $display("FAIL %s rd_data got %h want %h", nm, o_data, ed);
                    end
                end
            end else begin
                checks++;
                if ({o_rdy, o_err, o_oe, o_data} !== 11'd0) begin
                    errors++;
                    $display("FAIL %s quiet cycle %0d rdy/err/oe/data got %b%b%b/%h want 000/00", nm, c, o_rdy, o_err, o_oe, o_data);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; sel = 1'b0; addr_bus = 16'h0; mem_read = 1'b0; mem_write = 1'b0;
        wr_data = 8'h00; load_en = 1'b0; load_addr = 8'h00; load_data = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({rdy_a, err_a, oe_a, rd_data_a, rdy_b, err_b, oe_b, rd_data_b} !== 22'd0) begin
            errors++;
            $display("FAIL reset outputs got %b%b%b%h %b%b%b%h want all zero",
                     rdy_a, err_a, oe_a, rd_data_a, rdy_b, err_b, oe_b, rd_data_b);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_rom_load();
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            load_en = 1'b1;
            load_addr = 8'(i);
            load_data = (i == 0) ? 8'hA9 : 8'($urandom);
            rom_m[i] = load_data;
        end
        @(negedge clk);
        load_en = 1'b0;
        sel = 1'b0; do_access(16'h0000, 1'b1, 1'b0, 8'h00, "rom_read_w1");
        sel = 1'b1; do_access(16'h0000, 1'b1, 1'b0, 8'h00, "rom_read_w0");
    endtask

    task automatic test_ram_rw();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            do_access(16'h0120, 1'b0, 1'b1, 8'h5A, "ram_write");
            do_access(16'h0120, 1'b1, 1'b0, 8'h00, "ram_read");
        end
    endtask

    task automatic test_rom_write_err();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            do_access(16'h0005, 1'b0, 1'b1, 8'h77, "rom_write_err");
            do_access(16'h0005, 1'b1, 1'b0, 8'h00, "rom_unchanged");
        end
    endtask

    task automatic test_range_err();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            do_access(16'h0200, 1'b1, 1'b0, 8'h00, "oor_read");
            do_access(16'hF123, 1'b0, 1'b1, 8'h3C, "oor_write");
            do_access(16'h0120, 1'b1, 1'b1, 8'hC3, "both_strobes");
            do_access(16'h0120, 1'b1, 1'b0, 8'h00, "ram_after_both");
        end
    endtask

    task automatic test_load_collision();
        logic [7:0] old_v, new_v;
        sel = 1'b0;
        old_v = rom_m[8'h10];
        new_v = ~old_v;
        @(negedge clk);
        addr_bus = 16'h0010; mem_read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_read = 1'b0;
        load_en = 1'b1; load_addr = 8'h10; load_data = new_v;
        @(negedge clk);
        load_en = 1'b0;
        checks++;
        if ({o_rdy, o_oe, o_data} !== {1'b1, 1'b1, old_v}) begin
            errors++;
            $display("FAIL load_collision rdy/oe/data got %b%b/%h want 11/%h", o_rdy, o_oe, o_data, old_v);
        end
        rom_m[8'h10] = new_v;
        do_access(16'h0010, 1'b1, 1'b0, 8'h00, "load_after");
    endtask

    task automatic test_back_to_back();
        int j;
        sel = 1'b0;
        do_access(16'h0100, 1'b0, 1'b1, 8'($urandom), "b2b_init0");
        do_access(16'h0101, 1'b0, 1'b1, 8'($urandom), "b2b_init1");
        @(negedge clk);
        addr_bus = 16'h0100; mem_read = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            j = c / 3;
            checks++;
            if (c % 3 == 2) begin
                if ({o_rdy, o_err, o_oe, o_data} !== {3'b101, ram_m[0][j % 2]}) begin
                    errors++;
                    $display("FAIL b2b access %0d got rdy/err/oe=%b%b%b data %h want 101 %h",
                             j, o_rdy, o_err, o_oe, o_data, ram_m[0][j % 2]);
                end
                addr_bus = ((j + 1) % 2 == 1) ? 16'h0101 : 16'h0100;
                if (c == 17) mem_read = 1'b0;
            end else if (o_rdy !== 1'b0) begin
                errors++;
                $display("FAIL b2b gap cycle %0d rdy got %b want 0", c, o_rdy);
            end
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (o_rdy !== 1'b0) begin
                errors++;
                $display("FAIL b2b tail rdy got %b want 0", o_rdy);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        sel = 1'b0;
        do_access(16'h0110, 1'b0, 1'b1, 8'h33 ^ 8'($urandom_range(1, 255)), "mid_init");
        @(negedge clk);
        addr_bus = 16'h0110; mem_write = 1'b1; wr_data = 8'h33;
        @(posedge clk);
        #2 reset_n = 1'b0; mem_write = 1'b0;
        #1;
        checks++;
        if ({rdy_a, err_a, oe_a, rd_data_a} !== 11'd0) begin
            errors++;
            $display("FAIL reset_wait outputs got %b%b%b%h want 0", rdy_a, err_a, oe_a, rd_data_a);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (rdy_a !== 1'b0) begin
                errors++;
                $display("FAIL reset_wait rdy got %b want 0", rdy_a);
            end
        end
        reset_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (rdy_a !== 1'b0) begin
                errors++;
                $display("FAIL reset_release rdy got %b want 0", rdy_a);
            end
        end
        do_access(16'h0110, 1'b1, 1'b0, 8'h00, "mid_unchanged");

        @(negedge clk);
        addr_bus = 16'h0000; mem_read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_read = 1'b0;
        @(negedge clk);
        checks++;
        if ({rdy_a, oe_a, rd_data_a} !== {2'b11, rom_m[0]}) begin
            errors++;
            $display("FAIL reset_resp pre rdy/oe/data got %b%b/%h want 11/%h", rdy_a, oe_a, rd_data_a, rom_m[0]);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({rdy_a, err_a, oe_a, rd_data_a} !== 11'd0) begin
            errors++;
            $display("FAIL reset_resp outputs got %b%b%b%h want 0", rdy_a, err_a, oe_a, rd_data_a);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic rd, wr;
        int t;
        for (int n = 0; n < 60; n++) begin
            sel = 1'($urandom);
            case ($urandom % 4)
                0:       a = 16'($urandom % 256);
                1, 2:    a = 16'h0100 + 16'($urandom % 8);
                default: a = 16'h0200 + 16'($urandom % 16'hFE00);
            endcase
            t = int'($urandom % 5);
            rd = (t < 2) || (t == 4);
            wr = (t >= 2);
            do_access(a, rd, wr, 8'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_rom_load();
        test_ram_rw();
        test_rom_write_err();
        test_range_err();
        test_load_collision();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
